// File: rtl/bcd_seq_adder_pkg.sv
// bcd_seq_adder_pkg: shared FSM encodings, segment codes and digit-add helper for the serial BCD adder.
package bcd_seq_adder_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // Full 16-entry table so codes 10..15 fall on blank without a range check.
    localparam logic [15:0][6:0] SEG_LUT = {
        {6{SEG_BLANK}}, SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
        SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };
    localparam logic [4:0] BCD_MAX = 5'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] t;
        t = {1'b0, a} + {1'b0, b} + {4'b0, c};
        return t > BCD_MAX ? {1'b1, t[3:0] + BCD_ADJ} : {1'b0, t[3:0]};
    endfunction
endpackage

// File: rtl/bcd_seq_adder_if.sv
// bcd_seq_adder_if: operand/handshake/result bundle between operand registers and the serial BCD adder.
interface bcd_seq_adder_if #(parameter int DIGITS = 4);
    logic                      start_i;
    logic [4*DIGITS-1:0]       x_i;
    logic [4*DIGITS-1:0]       y_i;
    logic                      cin_i;
    logic                      busy_o;
    logic                      done_o;
    logic [4*DIGITS-1:0]       sum_o;
    logic                      cout_o;
    logic                      err_o;
    logic [7*(DIGITS+1)-1:0]   hex_o;

    modport master (output start_i, x_i, y_i, cin_i, input busy_o, done_o, sum_o, cout_o, err_o, hex_o);
    modport slave  (input start_i, x_i, y_i, cin_i, output busy_o, done_o, sum_o, cout_o, err_o, hex_o);
endinterface

// File: rtl/bcd_seq_adder_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low gfedcba segment decoder; 10..15 blank.
module bcd_to_seg7
    import bcd_seq_adder_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_LUT[d_i];
endmodule

// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder: serial LSD-first packed-BCD adder with START/BUSY/DONE handshake and registered HEX outputs.
module bcd_seq_adder
    import bcd_seq_adder_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input logic               clk,
    input logic               rst,
    bcd_seq_adder_if.slave    bus
);
    localparam int W  = 4 * DIGITS;
    localparam int HW = 7 * (DIGITS + 1);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_ZERO = SEG_ACTIVE_LOW != 0 ? SEG_0 : ~SEG_0;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, b_q, s_q, sum_q;
    logic [IW-1:0] i_q;
    logic          c_q, e_q, cout_q, err_q, busy_q, done_q;
    logic [HW-1:0] hex_q, hex_d;
    logic [3:0]    a_d, b_d;
    logic [4:0]    slice;
    logic          last;

    assign a_d   = a_q[4*i_q +: 4];
    assign b_d   = b_q[4*i_q +: 4];
    assign slice = bcd_add(a_d, b_d, c_q);
    assign last  = i_q == IW'(DIGITS - 1);

    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) state_d = bus.start_i ? S_ADD : S_IDLE;
        else if (state_q == S_ADD) state_d = last ? S_FIN : S_ADD;
        else state_d = S_IDLE;
    end

    // Decode the shadow sum/carry so HEX lands on the same edge as SUM.
    for (genvar k = 0; k <= DIGITS; k++) begin : g_seg
        logic [6:0] seg;
        if (k < DIGITS) begin : g_dig
            bcd_to_seg7 u_dec (.d_i(s_q[4*k +: 4]), .seg_o(seg));
        end else begin : g_carry
            bcd_to_seg7 u_dec (.d_i({3'b0, c_q}), .seg_o(seg));
        end
        assign hex_d[7*k +: 7] = SEG_ACTIVE_LOW != 0 ? seg : ~seg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            i_q     <= '0;
            c_q     <= 1'b0;
            e_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hex_q   <= {(DIGITS+1){SEG_ZERO}};
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != S_IDLE;
            done_q  <= state_q == S_FIN;
            if (state_q == S_IDLE && bus.start_i) begin
                a_q <= bus.x_i;
                b_q <= bus.y_i;
                c_q <= bus.cin_i;
                i_q <= '0;
                e_q <= 1'b0;
            end
            if (state_q == S_ADD) begin
                s_q[4*i_q +: 4] <= slice[3:0];
                c_q <= slice[4];
                e_q <= e_q | (a_d > 4'd9) | (b_d > 4'd9);
                i_q <= i_q + IW'(1);
            end
            if (state_q == S_FIN) begin
                sum_q  <= s_q;
                cout_q <= c_q;
                err_q  <= e_q;
                hex_q  <= hex_d;
            end
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.sum_o  = sum_q;
    assign bus.cout_o = cout_q;
    assign bus.err_o  = err_q;
    assign bus.hex_o  = hex_q;
endmodule
